ssd1306_spi_receiver: RTL and testbench

- Receiving end of the SSD1306 4-wire SPI link (sclk, sdin, cs, dc, reset) that the display controller drives.
- Oversamples the link with the system clock and assembles MSB-first bytes.
- Decodes command bytes into display state and turns data bytes into framebuffer write strobes, with SSD1306 address auto-increment.
- Used as an on-chip mirror or display model for loopback checking of the Tamagotchi display path.

---
 rtl/ssd1306_pkg.sv | 42 ++++
 rtl/ssd1306_spi_deserializer.sv | 109 ++++++++++
 rtl/ssd1306_spi_receiver.sv | 190 +++++++++++++++++++
 tb/tb_ssd1306_spi_receiver.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ssd1306_pkg.sv
// Shared SSD1306 definitions: command opcodes, addressing modes and decoder states.
// Used by both the display controller and the receiver-side mirror.
package ssd1306_pkg;

  localparam logic [7:0] CMD_DISPLAY_OFF  = 8'hAE;
  localparam logic [7:0] CMD_DISPLAY_ON   = 8'hAF;
  localparam logic [7:0] CMD_NORMAL       = 8'hA6;
  localparam logic [7:0] CMD_INVERT       = 8'hA7;
  localparam logic [7:0] CMD_SET_CONTRAST = 8'h81;
  localparam logic [7:0] CMD_ADDR_MODE    = 8'h20;
  localparam logic [7:0] CMD_COL_RANGE    = 8'h21;
  localparam logic [7:0] CMD_PAGE_RANGE   = 8'h22;
  localparam logic [7:0] CMD_MUX_RATIO    = 8'hA8;
  localparam logic [7:0] CMD_DISP_OFFSET  = 8'hD3;
  localparam logic [7:0] CMD_CLK_DIV      = 8'hD5;
  localparam logic [7:0] CMD_PRECHARGE    = 8'hD9;
  localparam logic [7:0] CMD_VCOMH        = 8'hDB;
  localparam logic [7:0] CMD_CHARGE_PUMP  = 8'h8D;

  typedef enum logic [1:0] {
    ADDR_HORIZ = 2'd0,
    ADDR_VERT  = 2'd1,
    ADDR_PAGE  = 2'd2
  } addr_mode_e;

  typedef enum logic [1:0] {
    DEC_CMD,
    DEC_ARG1,
    DEC_ARG2
  } dec_state_e;

  // Opcodes that are followed by at least one argument byte.
  function automatic logic cmd_takes_arg(input logic [7:0] op);
    case (op)
      CMD_SET_CONTRAST, CMD_ADDR_MODE, CMD_COL_RANGE, CMD_PAGE_RANGE,
      CMD_MUX_RATIO, CMD_DISP_OFFSET, CMD_CLK_DIV, CMD_PRECHARGE,
      CMD_VCOMH, CMD_CHARGE_PUMP: return 1'b1;
      default:                    return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ssd1306_spi_deserializer.sv
// SPI front end: input synchronizers, sclk rising-edge detect, MSB-first shifter.
// Optional frame checker enabled by SSD_RX_PROTOCOL_CHECK_EN (adds frame_err).
module ssd1306_spi_deserializer #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       spi_sclk,
  input  logic       spi_sdin,
  input  logic       spi_cs,
  input  logic       spi_dc,
  input  logic       spi_reset,
  output logic       soft_rst,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       byte_dc
`ifdef SSD_RX_PROTOCOL_CHECK_EN
  , output logic     frame_err
`endif
);

  logic [SYNC_STAGES-1:0] sclk_sync, sdin_sync, cs_sync, dc_sync, rst_sync;
  logic       sclk_s, sdin_s, cs_s, dc_s;
  logic       sclk_prev, cs_prev, sclk_rise;
  logic [6:0] shreg;
  logic [2:0] bit_cnt;

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign sdin_s    = sdin_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign dc_s      = dc_sync[SYNC_STAGES-1];
  assign soft_rst  = ~rst_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev;

  // Synchronizer chains; sclk and cs reset to their idle-high level so no false edge appears.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= '1;
      cs_sync   <= '1;
      rst_sync  <= '1;
      sdin_sync <= '0;
      dc_sync   <= '0;
      sclk_prev <= 1'b1;
      cs_prev   <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs};
      rst_sync  <= {rst_sync[SYNC_STAGES-2:0], spi_reset};
      sdin_sync <= {sdin_sync[SYNC_STAGES-2:0], spi_sdin};
      dc_sync   <= {dc_sync[SYNC_STAGES-2:0], spi_dc};
      sclk_prev <= sclk_s;
      cs_prev   <= cs_s;
    end
  end

  // Shift on sclk rising edges while selected; register the byte on the 8th edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg      <= '0;
      bit_cnt    <= '0;
      byte_valid <= 1'b0;
      byte_data  <= '0;
      byte_dc    <= 1'b0;
    end else if (soft_rst) begin
      shreg      <= '0;
      bit_cnt    <= '0;
      byte_valid <= 1'b0;
      byte_data  <= '0;
      byte_dc    <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      if (cs_s) begin
        bit_cnt <= '0;
      end else if (sclk_rise) begin
        shreg   <= {shreg[5:0], sdin_s};
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          byte_data  <= {shreg, sdin_s};
          byte_dc    <= dc_s;
          byte_valid <= 1'b1;
        end
      end
    end
  end

`ifdef SSD_RX_PROTOCOL_CHECK_EN
  logic [2:0] gap_cnt;

  // Sticky framing error: partial byte at deselect, or sclk edges closer than 6 clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gap_cnt   <= 3'd7;
      frame_err <= 1'b0;
    end else if (soft_rst) begin
      gap_cnt   <= 3'd7;
      frame_err <= 1'b0;
    end else begin
      if (sclk_rise) begin
        gap_cnt <= 3'd1;
        if (gap_cnt < 3'd6) frame_err <= 1'b1;
      end else if (gap_cnt != 3'd7) begin
        gap_cnt <= gap_cnt + 3'd1;
      end
      if (cs_s && !cs_prev && bit_cnt != 3'd0) frame_err <= 1'b1;
    end
  end
`endif

endmodule

// File: rtl/ssd1306_spi_receiver.sv
// SSD1306 SPI receiver / display model: command decoder, display state and
// framebuffer write strobes with address auto-increment.
// Optional SSD_RX_PROTOCOL_CHECK_EN adds the frame_err output.
module ssd1306_spi_receiver
  import ssd1306_pkg::*;
#(
  parameter int unsigned COLS        = 128,
  parameter int unsigned PAGES       = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       spi_sclk,
  input  logic       spi_sdin,
  input  logic       spi_cs,
  input  logic       spi_dc,
  input  logic       spi_reset,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       byte_dc,
  output logic       fb_we,
  output logic [9:0] fb_addr,
  output logic [7:0] fb_data,
  output logic       display_on,
  output logic [7:0] contrast,
  output logic       inverted,
  output logic [1:0] addr_mode
`ifdef SSD_RX_PROTOCOL_CHECK_EN
  , output logic     frame_err
`endif
);

  localparam logic [6:0] COL_LAST  = 7'(COLS - 1);
  localparam logic [2:0] PAGE_LAST = 3'(PAGES - 1);

  logic       soft_rst, cmd_vld, data_vld;
  dec_state_e state_q, state_d;
  logic [7:0] cmd_q;
  addr_mode_e mode_q;
  logic [6:0] col, col_start, col_end;
  logic [2:0] page, page_start, page_end;
  logic       disp_wr, inv_wr, contrast_wr, mode_wr;
  logic       col_start_wr, col_end_wr, page_start_wr, page_end_wr;

  ssd1306_spi_deserializer #(.SYNC_STAGES(SYNC_STAGES)) u_deser (
    .clk        (clk),
    .rst_n      (rst_n),
    .spi_sclk   (spi_sclk),
    .spi_sdin   (spi_sdin),
    .spi_cs     (spi_cs),
    .spi_dc     (spi_dc),
    .spi_reset  (spi_reset),
    .soft_rst   (soft_rst),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_dc    (byte_dc)
`ifdef SSD_RX_PROTOCOL_CHECK_EN
    , .frame_err (frame_err)
`endif
  );

  assign cmd_vld   = byte_valid & ~byte_dc;
  assign data_vld  = byte_valid & byte_dc;
  assign fb_we     = data_vld;
  assign fb_addr   = {page, col};
  assign fb_data   = byte_data;
  assign addr_mode = mode_q;

  // Decoder state register and latched opcode awaiting its arguments.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= DEC_CMD;
      cmd_q   <= '0;
    end else if (soft_rst) begin
      state_q <= DEC_CMD;
      cmd_q   <= '0;
    end else begin
      state_q <= state_d;
      if (cmd_vld && state_q == DEC_CMD) cmd_q <= byte_data;
    end
  end

  // Next-state: a data byte always abandons pending arguments.
  always_comb begin
    state_d = state_q;
    if (data_vld) begin
      state_d = DEC_CMD;
    end else if (cmd_vld) begin
      case (state_q)
        DEC_CMD:  if (cmd_takes_arg(byte_data)) state_d = DEC_ARG1;
        DEC_ARG1: state_d = (cmd_q == CMD_COL_RANGE || cmd_q == CMD_PAGE_RANGE) ? DEC_ARG2 : DEC_CMD;
        default:  state_d = DEC_CMD;
      endcase
    end
  end

  // Decoded register-write actions for the current command/argument byte.
  always_comb begin
    disp_wr       = 1'b0;
    inv_wr        = 1'b0;
    contrast_wr   = 1'b0;
    mode_wr       = 1'b0;
    col_start_wr  = 1'b0;
    col_end_wr    = 1'b0;
    page_start_wr = 1'b0;
    page_end_wr   = 1'b0;
    if (cmd_vld) begin
      case (state_q)
        DEC_CMD: begin
          disp_wr = (byte_data == CMD_DISPLAY_OFF) || (byte_data == CMD_DISPLAY_ON);
          inv_wr  = (byte_data == CMD_NORMAL) || (byte_data == CMD_INVERT);
        end
        DEC_ARG1: begin
          contrast_wr   = (cmd_q == CMD_SET_CONTRAST);
          mode_wr       = (cmd_q == CMD_ADDR_MODE) && (byte_data[1:0] != 2'd3);
          col_start_wr  = (cmd_q == CMD_COL_RANGE);
          page_start_wr = (cmd_q == CMD_PAGE_RANGE);
        end
        default: begin
          col_end_wr  = (cmd_q == CMD_COL_RANGE);
          page_end_wr = (cmd_q == CMD_PAGE_RANGE);
        end
      endcase
    end
  end

  // Display state, address windows and pointer auto-increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      display_on <= 1'b0;
      contrast   <= 8'h7F;
      inverted   <= 1'b0;
      mode_q     <= ADDR_PAGE;
      col_start  <= '0;
      col_end    <= COL_LAST;
      page_start <= '0;
      page_end   <= PAGE_LAST;
      col        <= '0;
      page       <= '0;
    end else if (soft_rst) begin
      display_on <= 1'b0;
      contrast   <= 8'h7F;
      inverted   <= 1'b0;
      mode_q     <= ADDR_PAGE;
      col_start  <= '0;
      col_end    <= COL_LAST;
      page_start <= '0;
      page_end   <= PAGE_LAST;
      col        <= '0;
      page       <= '0;
    end else begin
      if (disp_wr)     display_on <= byte_data[0];
      if (inv_wr)      inverted   <= byte_data[0];
      if (contrast_wr) contrast   <= byte_data;
      if (mode_wr)     mode_q     <= addr_mode_e'(byte_data[1:0]);
      if (col_end_wr)  col_end    <= byte_data[6:0];
      if (page_end_wr) page_end   <= byte_data[2:0];
      if (col_start_wr) begin
        col_start <= byte_data[6:0];
        col       <= byte_data[6:0];
      end
      if (page_start_wr) begin
        page_start <= byte_data[2:0];
        page       <= byte_data[2:0];
      end
      if (data_vld) begin
        case (mode_q)
          ADDR_HORIZ: begin
            if (col == col_end) begin
              col  <= col_start;
              page <= (page == page_end) ? page_start : page + 3'd1;
            end else begin
              col <= col + 7'd1;
            end
          end
          ADDR_VERT: begin
            if (page == page_end) begin
              page <= page_start;
              col  <= (col == col_end) ? col_start : col + 7'd1;
            end else begin
              page <= page + 3'd1;
            end
          end
          default: col <= (col == col_end) ? col_start : col + 7'd1;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ssd1306_spi_receiver.sv
// Self-checking bench for ssd1306_spi_receiver with a behavioural display model.
module tb_ssd1306_spi_receiver;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       spi_sclk = 1'b1;
  logic       spi_sdin = 1'b0;
  logic       spi_cs = 1'b1;
  logic       spi_dc = 1'b0;
  logic       spi_reset = 1'b1;
  logic       byte_valid, byte_dc, fb_we, display_on, inverted;
  logic [7:0] byte_data, fb_data, contrast;
  logic [9:0] fb_addr;
  logic [1:0] addr_mode;
`ifdef SSD_RX_PROTOCOL_CHECK_EN
  logic       frame_err;
`endif

  ssd1306_spi_receiver #(.COLS(128), .PAGES(8), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .spi_sclk   (spi_sclk),
    .spi_sdin   (spi_sdin),
    .spi_cs     (spi_cs),
    .spi_dc     (spi_dc),
    .spi_reset  (spi_reset),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_dc    (byte_dc),
    .fb_we      (fb_we),
    .fb_addr    (fb_addr),
    .fb_data    (fb_data),
    .display_on (display_on),
    .contrast   (contrast),
    .inverted   (inverted),
    .addr_mode  (addr_mode)
`ifdef SSD_RX_PROTOCOL_CHECK_EN
    , .frame_err (frame_err)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int bv_cnt = 0;
  logic [17:0] got_q[$];
  logic [17:0] exp_q[$];

  always @(negedge clk) begin
    if (byte_valid === 1'b1) bv_cnt++;
    if (fb_we === 1'b1) got_q.push_back({fb_addr, fb_data});
  end

  // Behavioural display model: state plus a count of argument bytes still owed.
  logic       m_on, m_inv;
  logic [7:0] m_contrast, m_pend;
  logic [1:0] m_mode;
  logic [6:0] m_cs, m_ce, m_col;
  logic [2:0] m_ps, m_pe, m_page;
  int         m_args, m_argi;

  function automatic void model_reset();
    m_on = 0; m_inv = 0; m_contrast = 8'h7F; m_mode = 2;
    m_cs = 0; m_ce = 127; m_ps = 0; m_pe = 7; m_col = 0; m_page = 0;
    m_pend = 0; m_args = 0; m_argi = 0;
  endfunction

  function automatic void model_byte(input logic [7:0] b, input logic dc);
    if (dc) begin
      m_args = 0;
      exp_q.push_back({m_page, m_col, b});
      if (m_mode == 1) begin
        if (m_page == m_pe) begin
          m_page = m_ps;
          m_col = (m_col == m_ce) ? m_cs : m_col + 7'd1;
        end else m_page = m_page + 3'd1;
      end else begin
        if (m_col == m_ce) begin
          m_col = m_cs;
          if (m_mode == 0) m_page = (m_page == m_pe) ? m_ps : m_page + 3'd1;
        end else m_col = m_col + 7'd1;
      end
    end else if (m_args == 0) begin
      m_pend = b; m_argi = 0;
      if (b == 8'hAE || b == 8'hAF) m_on = b[0];
      if (b == 8'hA6 || b == 8'hA7) m_inv = b[0];
      if (b == 8'h21 || b == 8'h22) m_args = 2;
      else if (b == 8'h81 || b == 8'h20 || b == 8'hA8 || b == 8'hD3 ||
               b == 8'hD5 || b == 8'hD9 || b == 8'hDB || b == 8'h8D) m_args = 1;
    end else begin
      case (m_pend)
        8'h81: m_contrast = b;
        8'h20: if (b[1:0] != 2'd3) m_mode = b[1:0];
        8'h21: if (m_argi == 0) begin m_cs = b[6:0]; m_col = b[6:0]; end else m_ce = b[6:0];
        8'h22: if (m_argi == 0) begin m_ps = b[2:0]; m_page = b[2:0]; end else m_pe = b[2:0];
        default: ;
      endcase
      m_argi++;
      m_args--;
    end
  endfunction

  task automatic spi_bits(input logic [7:0] b, input int n, input logic dc, input int lo, input int hi);
    for (int i = 7; i > 7 - n; i--) begin
      spi_sdin = b[i];
      spi_dc   = dc;
      spi_sclk = 1'b0;
      repeat (lo) @(negedge clk);
      spi_sclk = 1'b1;
      repeat (hi) @(negedge clk);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic dc);
    @(negedge clk);
    spi_cs = 1'b0;
    repeat (3) @(negedge clk);
    spi_bits(b, 8, dc, int'($urandom_range(5, 3)), int'($urandom_range(5, 3)));
    repeat (2) @(negedge clk);
    spi_cs = 1'b1;
    repeat (8) @(negedge clk);
    model_byte(b, dc);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    repeat (6) @(negedge clk);
    checks++;
    if ({display_on, contrast, inverted, addr_mode, byte_valid, byte_data, byte_dc, fb_we, fb_addr, fb_data}
        !== {1'b0, 8'h7F, 1'b0, 2'd2, 1'b0, 8'h00, 1'b0, 1'b0, 10'h000, 8'h00}) begin
      errors++;
      $display("FAIL reset_state on=%0b contrast=%h inv=%0b mode=%0d bv=%0b bd=%h addr=%h (exp 0 7f 0 2 0 00 000)",
               display_on, contrast, inverted, addr_mode, byte_valid, byte_data, fb_addr);
    end
  endtask

  task automatic test_init();
    logic [7:0] init_seq [23] = '{8'hAE, 8'h81, 8'h7F, 8'hA6, 8'h20, 8'h01, 8'hC8, 8'h40, 8'hA1, 8'hA8, 8'h3F, 8'hD3,
                                  8'h00, 8'hD5, 8'h80, 8'hD9, 8'h22, 8'hDB, 8'h20, 8'h8D, 8'h14, 8'hA4, 8'hAF};
    got_q.delete(); exp_q.delete(); bv_cnt = 0;
    foreach (init_seq[i]) send_byte(init_seq[i], 1'b0);
    checks++;
    if ({display_on, contrast, addr_mode, inverted} !== {1'b1, 8'h7F, 2'd1, 1'b0}) begin
      errors++;
      $display("FAIL init_state on=%0b contrast=%h mode=%0d inv=%0b (exp 1 7f 1 0)", display_on, contrast, addr_mode, inverted);
    end
    checks++;
    if (got_q.size() != 0 || bv_cnt != 23) begin
      errors++;
      $display("FAIL init_counts fb_we=%0d bytes=%0d (exp 0 23)", got_q.size(), bv_cnt);
    end
  endtask

  task automatic test_vertical();
    got_q.delete(); exp_q.delete();
    for (int k = 0; k < 9; k++) send_byte(8'(8'h11 * (k + 1)), 1'b1);
    checks++;
    if (got_q.size() != 9) begin
      errors++;
      $display("FAIL vert_count got %0d exp 9", got_q.size());
    end
    for (int k = 0; k < 9 && k < got_q.size(); k++) begin
      checks++;
      if (got_q[k] !== {(k < 8) ? 10'(k << 7) : 10'h001, 8'(8'h11 * (k + 1))}) begin
        errors++;
        $display("FAIL vert_write[%0d] got addr=%h data=%h exp addr=%h data=%h", k, got_q[k][17:8], got_q[k][7:0],
                 (k < 8) ? 10'(k << 7) : 10'h001, 8'(8'h11 * (k + 1)));
      end
    end
  endtask

  task automatic test_window();
    logic [7:0] cmds [8] = '{8'h21, 8'h04, 8'h05, 8'h22, 8'h06, 8'h07, 8'h20, 8'h00};
    logic [9:0] exp_addr [5] = '{10'h304, 10'h305, 10'h384, 10'h385, 10'h304};
    foreach (cmds[i]) send_byte(cmds[i], 1'b0);
    got_q.delete(); exp_q.delete();
    for (int k = 0; k < 5; k++) send_byte(8'($urandom), 1'b1);
    checks++;
    if (got_q.size() != 5) begin
      errors++;
      $display("FAIL window_count got %0d exp 5", got_q.size());
    end
    for (int k = 0; k < 5 && k < got_q.size(); k++) begin
      checks++;
      if (got_q[k] !== {exp_addr[k], exp_q[k][7:0]}) begin
        errors++;
        $display("FAIL window_write[%0d] got %h exp %h", k, got_q[k], {exp_addr[k], exp_q[k][7:0]});
      end
    end
  endtask

  task automatic test_abort();
    send_byte(8'hA6, 1'b0);
    bv_cnt = 0;
    @(negedge clk);
    spi_cs = 1'b0;
    repeat (3) @(negedge clk);
    spi_bits(8'hA7, 5, 1'b0, 4, 4);
    spi_cs = 1'b1;
    repeat (8) @(negedge clk);
    send_byte(8'hA7, 1'b0);
    checks++;
    if (bv_cnt != 1 || inverted !== 1'b1) begin
      errors++;
      $display("FAIL abort_partial bytes=%0d inv=%0b (exp 1 1)", bv_cnt, inverted);
    end
`ifdef SSD_RX_PROTOCOL_CHECK_EN
    checks++;
    if (frame_err !== 1'b1) begin
      errors++;
      $display("FAIL abort_frame_err got %0b exp 1", frame_err);
    end
`endif
  endtask

  task automatic test_async_reset();
    send_byte(8'hAF, 1'b0);
    @(negedge clk);
    spi_cs = 1'b0;
    repeat (3) @(negedge clk);
    spi_bits(8'h3C, 4, 1'b1, 4, 4);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({display_on, contrast, inverted, addr_mode, byte_valid, byte_data, fb_we, fb_addr}
        !== {1'b0, 8'h7F, 1'b0, 2'd2, 1'b0, 8'h00, 1'b0, 10'h000}) begin
      errors++;
      $display("FAIL async_reset on=%0b contrast=%h inv=%0b mode=%0d bd=%h addr=%h (exp 0 7f 0 2 00 000)",
               display_on, contrast, inverted, addr_mode, byte_data, fb_addr);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    bv_cnt = 0;
    repeat (4) @(negedge clk);
    spi_bits(8'hAF, 8, 1'b0, 4, 4);
    repeat (8) @(negedge clk);
    model_byte(8'hAF, 1'b0);
    checks++;
    if (display_on !== 1'b1 || byte_data !== 8'hAF || bv_cnt != 1) begin
      errors++;
      $display("FAIL post_reset_byte on=%0b data=%h bytes=%0d (exp 1 af 1)", display_on, byte_data, bv_cnt);
    end
    spi_cs = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_data_in_arg();
    got_q.delete(); exp_q.delete();
    send_byte(8'h20, 1'b0);
    send_byte(8'h55, 1'b1);
    checks++;
    if (addr_mode !== 2'd2) begin
      errors++;
      $display("FAIL arg_abort_mode got %0d exp 2", addr_mode);
    end
    checks++;
    if (got_q.size() != 1 || got_q[0] !== {10'h000, 8'h55} || exp_q[0] !== {10'h000, 8'h55}) begin
      errors++;
      $display("FAIL arg_abort_write count=%0d got %h exp %h", got_q.size(), (got_q.size() > 0) ? got_q[0] : 18'h0, 18'h00055);
    end
  endtask

  task automatic test_spi_reset();
    send_byte(8'h81, 1'b0);
    send_byte(8'h33, 1'b0);
    send_byte(8'hAF, 1'b0);
    @(negedge clk);
    spi_reset = 1'b0;
    repeat (6) @(negedge clk);
    spi_reset = 1'b1;
    repeat (6) @(negedge clk);
    model_reset();
    checks++;
    if ({display_on, contrast, inverted, addr_mode, fb_addr} !== {1'b0, 8'h7F, 1'b0, 2'd2, 10'h000}) begin
      errors++;
      $display("FAIL spi_reset on=%0b contrast=%h inv=%0b mode=%0d addr=%h (exp 0 7f 0 2 000)",
               display_on, contrast, inverted, addr_mode, fb_addr);
    end
`ifdef SSD_RX_PROTOCOL_CHECK_EN
    checks++;
    if (frame_err !== 1'b0) begin
      errors++;
      $display("FAIL spi_reset_frame_err got %0b exp 0", frame_err);
    end
`endif
  endtask

  task automatic test_random();
    logic [7:0] tbl [12] = '{8'hAE, 8'hAF, 8'hA6, 8'hA7, 8'h81, 8'h20, 8'h21, 8'h22, 8'hA8, 8'hD3, 8'hE3, 8'h40};
    logic [7:0] b;
    logic       dc;
    got_q.delete(); exp_q.delete();
    for (int n = 0; n < 60; n++) begin
      dc = ($urandom_range(99) < 35);
      if (dc || m_args > 0) b = 8'($urandom);
      else b = tbl[$urandom_range(11)];
      send_byte(b, dc);
    end
    checks++;
    if ({display_on, contrast, inverted, addr_mode} !== {m_on, m_contrast, m_inv, m_mode}) begin
      errors++;
      $display("FAIL random_state got on=%0b c=%h inv=%0b mode=%0d exp on=%0b c=%h inv=%0b mode=%0d",
               display_on, contrast, inverted, addr_mode, m_on, m_contrast, m_inv, m_mode);
    end
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL random_count got %0d exp %0d", got_q.size(), exp_q.size());
    end
    for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
      checks++;
      if (got_q[k] !== exp_q[k]) begin
        errors++;
        $display("FAIL random_write[%0d] got addr=%h data=%h exp addr=%h data=%h",
                 k, got_q[k][17:8], got_q[k][7:0], exp_q[k][17:8], exp_q[k][7:0]);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_init();
    test_vertical();
    test_window();
    test_abort();
    test_async_reset();
    test_data_in_arg();
    test_spi_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
